// File: rtl/hdmi_timing_pkg.sv
// Shared types and 720p60 default timing for the raster timing generator.
// Contents:
//   axis_state_t - phase of one timing axis (active, front porch, sync, back porch)
//   Def*         - 1280x720 @ 60 Hz timing constants
//   total_len()  - sum of the four phase lengths of an axis
package hdmi_timing_pkg;

  typedef enum logic [1:0] {ACT, FP, SY, BP} axis_state_t;

  localparam int unsigned DefHActive = 1280;
  localparam int unsigned DefHFront  = 110;
  localparam int unsigned DefHSync   = 40;
  localparam int unsigned DefHBack   = 220;
  localparam int unsigned DefVActive = 720;
  localparam int unsigned DefVFront  = 5;
  localparam int unsigned DefVSync   = 5;
  localparam int unsigned DefVBack   = 20;

  function automatic int unsigned total_len(int unsigned act, int unsigned fp,
                                            int unsigned sy, int unsigned bp);
    return act + fp + sy + bp;
  endfunction

endpackage

// File: rtl/video_timing_axis.sv
// One timing axis: a 4-phase FSM (ACT -> FP -> SY -> BP -> ACT) with a per-phase
// counter running 0..len-1. Zero-length porches are skipped.
// Ports:
//   clk_i     - clock
//   rst_i     - synchronous active-high reset (to ACT, count 0)
//   advance_i - step the counter this cycle
//   state_o   - current phase
//   pos_o     - counter value while in ACT, else 0
//   wrap_o    - high on the advancing last count of the final phase (axis restarts)
module video_timing_axis
  import hdmi_timing_pkg::*;
#(
  parameter int unsigned ACT_LEN = 1,
  parameter int unsigned FP_LEN  = 0,
  parameter int unsigned SY_LEN  = 1,
  parameter int unsigned BP_LEN  = 0,
  parameter int unsigned CW      = 12
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          advance_i,
  output axis_state_t   state_o,
  output logic [CW-1:0] pos_o,
  output logic          wrap_o
);

  localparam logic [CW-1:0] ActLast = CW'(ACT_LEN - 1);
  localparam logic [CW-1:0] FpLast  = CW'(FP_LEN - 1);
  localparam logic [CW-1:0] SyLast  = CW'(SY_LEN - 1);
  localparam logic [CW-1:0] BpLast  = CW'(BP_LEN - 1);

  axis_state_t   state_q, state_d, state_nxt;
  logic [CW-1:0] cnt_q, cnt_d, len_last;
  logic          last;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ACT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    len_last  = ActLast;
    state_nxt = state_q;
    unique case (state_q)
      ACT: begin
        len_last  = ActLast;
        state_nxt = (FP_LEN != 0) ? FP : SY;
      end
      FP: begin
        len_last  = FpLast;
        state_nxt = SY;
      end
      SY: begin
        len_last  = SyLast;
        state_nxt = (BP_LEN != 0) ? BP : ACT;
      end
      BP: begin
        len_last  = BpLast;
        state_nxt = ACT;
      end
      default: ;
    endcase
    last    = (cnt_q == len_last);
    state_d = state_q;
    cnt_d   = cnt_q;
    if (advance_i) begin
      if (last) begin
        state_d = state_nxt;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Outputs
  always_comb begin
    state_o = state_q;
    pos_o   = (state_q == ACT) ? cnt_q : '0;
    wrap_o  = advance_i & last & (state_nxt == ACT) & (state_q != ACT);
  end

endmodule

// File: rtl/video_timing_ctrl.sv
// Raster timing generator for the HDMI output path (hdmi_clk domain).
// Issues pixel-coordinate requests to the pixel source and emits the
// {display_enable, vsync, hsync} word for hdmi.hve, delayed LEAD clocks so it
// lines up with the pixel source's rgb response.
// Ports:
//   i_hdmi_clk    - pixel clock
//   i_reset       - synchronous active-high reset
//   o_req         - request for visible pixel (o_x, o_y)
//   o_x, o_y      - requested column/row, 0 outside active video
//   o_frame_start - pulse with the request for (0,0)
//   o_line_start  - pulse with the request for x=0 of each visible line
//   o_hve         - {de, vsync, hsync}, LEAD clocks behind o_req
module video_timing_ctrl
  import hdmi_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DefHActive,
  parameter int unsigned H_FRONT    = DefHFront,
  parameter int unsigned H_SYNC     = DefHSync,
  parameter int unsigned H_BACK     = DefHBack,
  parameter int unsigned V_ACTIVE   = DefVActive,
  parameter int unsigned V_FRONT    = DefVFront,
  parameter int unsigned V_SYNC     = DefVSync,
  parameter int unsigned V_BACK     = DefVBack,
  parameter bit          H_SYNC_POL = 1'b1,
  parameter bit          V_SYNC_POL = 1'b1,
  parameter int unsigned LEAD       = 2,
  parameter int unsigned CW         = 12
) (
  input  logic          i_hdmi_clk,
  input  logic          i_reset,
  output logic          o_req,
  output logic [CW-1:0] o_x,
  output logic [CW-1:0] o_y,
  output logic          o_frame_start,
  output logic          o_line_start,
  output logic [2:0]    o_hve
);

  localparam int unsigned HTotal = total_len(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned VTotal = total_len(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
  localparam logic [2:0]  HveIdle = {1'b0, ~V_SYNC_POL, ~H_SYNC_POL};

  if (HTotal >= (32'd1 << CW) || VTotal >= (32'd1 << CW)) begin : g_width_chk
    $error("video_timing_ctrl: CW too narrow for H/V totals");
  end
  if (H_ACTIVE == 0 || V_ACTIVE == 0 || H_SYNC == 0 || V_SYNC == 0) begin : g_len_chk
    $error("video_timing_ctrl: active and sync lengths must be nonzero");
  end
  if (LEAD > 15) begin : g_lead_chk
    $error("video_timing_ctrl: LEAD must be 0..15");
  end

  axis_state_t   h_state, v_state;
  logic [CW-1:0] h_pos, v_pos;
  logic          h_wrap, v_wrap;

  video_timing_axis #(
    .ACT_LEN(H_ACTIVE), .FP_LEN(H_FRONT), .SY_LEN(H_SYNC), .BP_LEN(H_BACK), .CW(CW)
  ) u_h_axis (
    .clk_i    (i_hdmi_clk),
    .rst_i    (i_reset),
    .advance_i(1'b1),
    .state_o  (h_state),
    .pos_o    (h_pos),
    .wrap_o   (h_wrap)
  );

  // Vertical phase only moves at end of line, so vsync edges land on h position 0.
  video_timing_axis #(
    .ACT_LEN(V_ACTIVE), .FP_LEN(V_FRONT), .SY_LEN(V_SYNC), .BP_LEN(V_BACK), .CW(CW)
  ) u_v_axis (
    .clk_i    (i_hdmi_clk),
    .rst_i    (i_reset),
    .advance_i(h_wrap),
    .state_o  (v_state),
    .pos_o    (v_pos),
    .wrap_o   (v_wrap)
  );

  logic          req_q, req_d, fs_q, fs_d, ls_q, ls_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  // Set while the axes sit at (0,0): after reset or the cycle after end of frame.
  logic          sof_q, sof_d;
  logic          de, vs, hs;
  logic [2:0]    pipe_q [LEAD+1];
  logic [2:0]    pipe_d [LEAD+1];

  always_comb begin
    de     = (h_state == ACT) && (v_state == ACT);
    hs     = (h_state == SY) ? H_SYNC_POL : ~H_SYNC_POL;
    vs     = (v_state == SY) ? V_SYNC_POL : ~V_SYNC_POL;
    req_d  = de;
    x_d    = de ? h_pos : '0;
    y_d    = de ? v_pos : '0;
    ls_d   = de && (h_pos == '0);
    fs_d   = de && sof_q;
    sof_d  = v_wrap;
    pipe_d[0] = {de, vs, hs};
    for (int unsigned i = 1; i <= LEAD; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge i_hdmi_clk) begin
    if (i_reset) begin
      req_q <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      fs_q  <= 1'b0;
      ls_q  <= 1'b0;
      sof_q <= 1'b1;
      for (int unsigned i = 0; i <= LEAD; i++) begin
        pipe_q[i] <= HveIdle;
      end
    end else begin
      req_q <= req_d;
      x_q   <= x_d;
      y_q   <= y_d;
      fs_q  <= fs_d;
      ls_q  <= ls_d;
      sof_q <= sof_d;
      for (int unsigned i = 0; i <= LEAD; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  always_comb begin
    o_req         = req_q;
    o_x           = x_q;
    o_y           = y_q;
    o_frame_start = fs_q;
    o_line_start  = ls_q;
    o_hve         = pipe_q[LEAD];
  end

endmodule

// File: tb/tb_video_timing_ctrl.sv
module tb_video_timing_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  // Small config: H 8/2/2/2 (14), V 4/1/1/1 (7), frame 98 clocks.
  logic        req_s, fs_s, ls_s, req_n, fs_n, ls_n, req_0, fs_0, ls_0, req_f, fs_f, ls_f;
  logic [11:0] x_s, y_s, x_n, y_n, x_0, y_0, x_f, y_f;
  logic [2:0]  hve_s, hve_n, hve_0, hve_f;
  logic        req_b, fs_b, ls_b;
  logic [11:0] x_b, y_b;
  logic [2:0]  hve_b;

  video_timing_ctrl #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2), .V_ACTIVE(4), .V_FRONT(1),
    .V_SYNC(1), .V_BACK(1), .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .LEAD(3), .CW(12)
  ) u_small (
    .i_hdmi_clk(clk), .i_reset(rst), .o_req(req_s), .o_x(x_s), .o_y(y_s),
    .o_frame_start(fs_s), .o_line_start(ls_s), .o_hve(hve_s)
  );

  video_timing_ctrl #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2), .V_ACTIVE(4), .V_FRONT(1),
    .V_SYNC(1), .V_BACK(1), .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .LEAD(3), .CW(12)
  ) u_neg (
    .i_hdmi_clk(clk), .i_reset(rst), .o_req(req_n), .o_x(x_n), .o_y(y_n),
    .o_frame_start(fs_n), .o_line_start(ls_n), .o_hve(hve_n)
  );

  video_timing_ctrl #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2), .V_ACTIVE(4), .V_FRONT(1),
    .V_SYNC(1), .V_BACK(1), .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .LEAD(0), .CW(12)
  ) u_lead0 (
    .i_hdmi_clk(clk), .i_reset(rst), .o_req(req_0), .o_x(x_0), .o_y(y_0),
    .o_frame_start(fs_0), .o_line_start(ls_0), .o_hve(hve_0)
  );

  video_timing_ctrl #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2), .V_ACTIVE(4), .V_FRONT(1),
    .V_SYNC(1), .V_BACK(1), .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .LEAD(15), .CW(12)
  ) u_lead15 (
    .i_hdmi_clk(clk), .i_reset(rst), .o_req(req_f), .o_x(x_f), .o_y(y_f),
    .o_frame_start(fs_f), .o_line_start(ls_f), .o_hve(hve_f)
  );

  video_timing_ctrl u_720 (
    .i_hdmi_clk(clk), .i_reset(rst), .o_req(req_b), .o_x(x_b), .o_y(y_b),
    .o_frame_start(fs_b), .o_line_start(ls_b), .o_hve(hve_b)
  );

  // Raw {de, vs, hs} for small config at registered cycle k after reset release.
  function automatic logic [2:0] raw_s(int k, logic hp, logic vp);
    int p, x, l;
    logic de, hs, vs;
    p  = k % 98;
    x  = p % 14;
    l  = p / 14;
    de = (x < 8) && (l < 4);
    hs = (x >= 10 && x < 12) ? hp : ~hp;
    vs = (l == 5) ? vp : ~vp;
    return {de, vs, hs};
  endfunction

  function automatic logic [2:0] hve_exp(int k, int lead, logic hp, logic vp);
    if (k < lead) return {1'b0, ~vp, ~hp};
    return raw_s(k - lead, hp, vp);
  endfunction

  function automatic int x_exp(int k);
    int p;
    p = k % 98;
    return ((p % 14) < 8 && (p / 14) < 4) ? (p % 14) : 0;
  endfunction

  function automatic int y_exp(int k);
    int p;
    p = k % 98;
    return ((p % 14) < 8 && (p / 14) < 4) ? (p / 14) : 0;
  endfunction

  // After return, the next negedge shows registered cycle k=0.
  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (req_s !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", req_s); end
    checks++; if (x_s !== 12'd0 || y_s !== 12'd0) begin
      errors++; $display("FAIL reset_xy got=%0d,%0d exp=0,0", x_s, y_s);
    end
    checks++; if (fs_s !== 1'b0 || ls_s !== 1'b0) begin
      errors++; $display("FAIL reset_pulses got fs=%b ls=%b exp=0,0", fs_s, ls_s);
    end
    checks++; if (hve_s !== 3'b000) begin errors++; $display("FAIL reset_hve got=%b exp=000", hve_s); end
    checks++; if (hve_n !== 3'b011) begin errors++; $display("FAIL reset_hve_neg got=%b exp=011", hve_n); end
    checks++; if (hve_f !== 3'b000) begin errors++; $display("FAIL reset_hve_l15 got=%b exp=000", hve_f); end
    checks++; if (req_b !== 1'b0 || hve_b !== 3'b000) begin
      errors++; $display("FAIL reset_720 got req=%b hve=%b exp 0,000", req_b, hve_b);
    end
  endtask

  task automatic test_raster();
    int nreq, nfs, nls;
    nreq = 0; nfs = 0; nls = 0;
    release_reset();
    for (int k = 0; k < 196; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++; if (req_s !== 1'b1 || fs_s !== 1'b1 || ls_s !== 1'b1) begin
          errors++; $display("FAIL first_edge got req=%b fs=%b ls=%b exp 1,1,1", req_s, fs_s, ls_s);
        end
      end
      checks++; if (req_s !== raw_s(k, 1'b1, 1'b1)[2]) begin
        errors++; $display("FAIL raster_req k=%0d got=%b", k, req_s);
      end
      checks++; if (x_s !== 12'(x_exp(k)) || y_s !== 12'(y_exp(k))) begin
        errors++; $display("FAIL raster_xy k=%0d got=%0d,%0d exp=%0d,%0d", k, x_s, y_s,
                           x_exp(k), y_exp(k));
      end
      checks++; if (fs_s !== ((k % 98) == 0)) begin
        errors++; $display("FAIL raster_fs k=%0d got=%b", k, fs_s);
      end
      checks++; if (ls_s !== ((k % 14) == 0 && (k % 98) < 56)) begin
        errors++; $display("FAIL raster_ls k=%0d got=%b", k, ls_s);
      end
      nreq += int'(req_s); nfs += int'(fs_s); nls += int'(ls_s);
    end
    checks++; if (nreq != 64) begin errors++; $display("FAIL req_count got=%0d exp=64", nreq); end
    checks++; if (nfs != 2) begin errors++; $display("FAIL fs_count got=%0d exp=2", nfs); end
    checks++; if (nls != 8) begin errors++; $display("FAIL ls_count got=%0d exp=8", nls); end
  endtask

  task automatic test_hve_rise();
    int first_s, first_0, first_f;
    first_s = -1; first_0 = -1; first_f = -1;
    release_reset();
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (first_s < 0 && hve_s[2] === 1'b1) first_s = k;
      if (first_0 < 0 && hve_0[2] === 1'b1) first_0 = k;
      if (first_f < 0 && hve_f[2] === 1'b1) first_f = k;
    end
    // k counts from the first edge after release, so edge number = k+1.
    checks++; if (first_s != 3) begin errors++; $display("FAIL de_rise_l3 got=%0d exp=3", first_s); end
    checks++; if (first_0 != 0) begin errors++; $display("FAIL de_rise_l0 got=%0d exp=0", first_0); end
    checks++; if (first_f != 15) begin errors++; $display("FAIL de_rise_l15 got=%0d exp=15", first_f); end
  endtask

  task automatic test_syncs();
    int nhs, hs_first, nvs, vs_first;
    nhs = 0; hs_first = -1; nvs = 0; vs_first = -1;
    release_reset();
    for (int k = 0; k < 110; k++) begin
      @(negedge clk);
      if (k >= 3 && k < 17 && hve_s[0] === 1'b1) begin
        nhs++;
        if (hs_first < 0) hs_first = k;
      end
      if (k >= 3 && k < 101 && hve_s[1] === 1'b1) begin
        nvs++;
        if (vs_first < 0) vs_first = k;
      end
      checks++; if (hve_n !== hve_exp(k, 3, 1'b0, 1'b0)) begin
        errors++; $display("FAIL neg_pol k=%0d got=%b exp=%b", k, hve_n, hve_exp(k, 3, 1'b0, 1'b0));
      end
    end
    checks++; if (nhs != 2) begin errors++; $display("FAIL hsync_len got=%0d exp=2", nhs); end
    checks++; if (hs_first != 13) begin errors++; $display("FAIL hsync_start got=%0d exp=13", hs_first); end
    checks++; if (nvs != 14) begin errors++; $display("FAIL vsync_len got=%0d exp=14", nvs); end
    checks++; if (vs_first != 73) begin errors++; $display("FAIL vsync_start got=%0d exp=73", vs_first); end
  endtask

  task automatic test_alignment();
    release_reset();
    for (int k = 0; k < 220; k++) begin
      @(negedge clk);
      checks++; if (hve_s !== hve_exp(k, 3, 1'b1, 1'b1)) begin
        errors++; $display("FAIL align_l3 k=%0d got=%b exp=%b", k, hve_s, hve_exp(k, 3, 1'b1, 1'b1));
      end
      checks++; if (hve_0 !== hve_exp(k, 0, 1'b1, 1'b1) || hve_0[2] !== req_0) begin
        errors++; $display("FAIL align_l0 k=%0d got=%b req=%b exp=%b", k, hve_0, req_0,
                           hve_exp(k, 0, 1'b1, 1'b1));
      end
      checks++; if (hve_f !== hve_exp(k, 15, 1'b1, 1'b1)) begin
        errors++; $display("FAIL align_l15 k=%0d got=%b exp=%b", k, hve_f, hve_exp(k, 15, 1'b1, 1'b1));
      end
    end
  endtask

  task automatic test_mid_reset();
    release_reset();
    for (int k = 0; k <= 33; k++) @(negedge clk);
    checks++; if (x_s !== 12'd5 || y_s !== 12'd2) begin
      errors++; $display("FAIL mid_pos got=%0d,%0d exp=5,2", x_s, y_s);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (req_s !== 1'b0 || hve_s !== 3'b000 || hve_n !== 3'b011) begin
        errors++; $display("FAIL mid_rst i=%0d got req=%b hve=%b hve_neg=%b", i, req_s, hve_s, hve_n);
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 98; k++) begin
      @(negedge clk);
      checks++; if (req_s !== raw_s(k, 1'b1, 1'b1)[2] || x_s !== 12'(x_exp(k)) ||
                    y_s !== 12'(y_exp(k)) || fs_s !== (k == 0)) begin
        errors++; $display("FAIL restart k=%0d got req=%b x=%0d y=%0d fs=%b", k, req_s, x_s, y_s, fs_s);
      end
      checks++; if (hve_s !== hve_exp(k, 3, 1'b1, 1'b1)) begin
        errors++; $display("FAIL restart_hve k=%0d got=%b exp=%b", k, hve_s, hve_exp(k, 3, 1'b1, 1'b1));
      end
    end
  endtask

  // 720p: first two lines plus a few clocks of the third.
  task automatic test_720();
    int nreq, nfs, x, xd;
    logic de, ede;
    logic [2:0] ehve;
    nreq = 0; nfs = 0;
    release_reset();
    for (int k = 0; k < 3305; k++) begin
      @(negedge clk);
      x  = k % 1650;
      de = (x < 1280);
      checks++; if (req_b !== de || x_b !== 12'(de ? x : 0) || y_b !== 12'(de ? k / 1650 : 0)) begin
        errors++; $display("FAIL p720 k=%0d got req=%b x=%0d y=%0d", k, req_b, x_b, y_b);
      end
      if (k < 2) ehve = 3'b000;
      else begin
        xd   = (k - 2) % 1650;
        ede  = (xd < 1280);
        ehve = {ede, 1'b0, (xd >= 1390 && xd < 1430)};
      end
      checks++; if (hve_b !== ehve) begin
        errors++; $display("FAIL p720_hve k=%0d got=%b exp=%b", k, hve_b, ehve);
      end
      if (k == 1279) begin
        checks++; if (x_b !== 12'd1279 || req_b !== 1'b1) begin
          errors++; $display("FAIL p720_last_x got=%0d exp=1279", x_b);
        end
      end
      if (k < 3300) begin
        nreq += int'(req_b);
        nfs  += int'(fs_b);
      end
    end
    checks++; if (nreq != 2560) begin errors++; $display("FAIL p720_req_count got=%0d exp=2560", nreq); end
    checks++; if (nfs != 1) begin errors++; $display("FAIL p720_fs_count got=%0d exp=1", nfs); end
  endtask

  initial begin
    test_reset();
    test_raster();
    test_hve_rise();
    test_syncs();
    test_alignment();
    test_mid_reset();
    test_720();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
